// File: rtl/serial_adder.sv
// serial_adder: bit-serial A+B+cin, LSB first, one full-adder step per clock
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CW-1:0] cnt;
  logic carry, a_msb, b_msb, s_bit, c_next;
  always_comb begin
    s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
    c_next = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      S      <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else if (state != RUN && start) begin
      state  <= RUN;
      busy   <= 1'b1;
      done   <= 1'b0;
      a_sh   <= A;
      b_sh   <= B;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= cin;
      a_msb  <= A[WIDTH-1];
      b_msb  <= B[WIDTH-1];
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
      carry  <= c_next;
      cnt    <= cnt + CW'(1);
      if (cnt == CW'(WIDTH - 1)) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        S     <= {s_bit, sum_sh[WIDTH-1:1]};
        cout  <= c_next;
        ovf   <= (a_msb == b_msb) && (s_bit != a_msb);
      end
    end else begin
      state <= IDLE;
      done  <= 1'b0;
    end
  end
endmodule
